// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU command sequencer slice.
//   - ALU_W        : ALU data width (4 bits)
//   - alu_op_e     : opcode encoding seen on alu_op / cmd_op
//   - alu_cmd_t    : one buffered command {a, b, op}
//   - alu_cmd_chain_t : command plus the chain flag, used only when the
//                    ALU_SEQ_CHAIN_EN build option is enabled
//   - alu_rsp_t    : one buffered response {result, carry, zero}
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_AND = 2'b10,
        ALU_OP_OR  = 2'b11
    } alu_op_e;

    typedef logic [ALU_W-1:0] alu_data_t;

    typedef struct packed {
        alu_data_t  a;
        alu_data_t  b;
        logic [1:0] op;
    } alu_cmd_t;

    typedef struct packed {
        logic     chain;
        alu_cmd_t cmd;
    } alu_cmd_chain_t;

    typedef struct packed {
        alu_data_t result;
        logic      carry;
        logic      zero;
    } alu_rsp_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Bundles the three buses around the sequencer:
//   command side : cmd_valid/cmd_ready handshake with cmd_a, cmd_b, cmd_op,
//                  cmd_chain
//   ALU side     : registered operands alu_a/alu_b/alu_op out, registered
//                  alu_result/alu_carry/alu_zero back
//   response side: rsp_valid/rsp_ready handshake with rsp_result, rsp_carry,
//                  rsp_zero
// Modports: slave = the sequencer, master = its environment (producer,
// ALU and consumer).
// ----------------------------------------------------------------------------
interface alu_cmd_sequencer_if;
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    alu_data_t        cmd_a;
    alu_data_t        cmd_b;
    logic [1:0]       cmd_op;
    logic             cmd_chain;

    alu_data_t        alu_a;
    alu_data_t        alu_b;
    logic [1:0]       alu_op;
    alu_data_t        alu_result;
    logic             alu_carry;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    alu_data_t        rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_carry, alu_zero,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_carry, alu_zero,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/alu_sync_fifo.sv
// ----------------------------------------------------------------------------
// alu_sync_fifo
// Single-clock FIFO with a registered occupancy count. Full/empty are left
// to the user, who derives them from count_o so that both come straight
// from registered state.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push_i      : write data_i this edge (ignored when full unless popping)
//   data_i      : write data
//   pop_i       : discard head this edge (ignored when empty)
//   data_o      : head entry, forced to zero while empty
//   count_o     : number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    // A push on full is accepted when the head leaves on the same edge;
    // the write then lands in the slot being vacated.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_i);

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Wrapper around a registered 4-bit ALU. Commands are buffered in a FIFO and
// issued at most one per cycle onto the ALU operand registers. Two pipeline
// valid bits follow each issued command through the ALU's one-cycle latency
// and the result is captured into a response FIFO. Issue is throttled by a
// credit check so that a captured result always finds room.
// Parameters: CMD_DEPTH, RSP_DEPTH (power of two, >= 2)
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; drops everything queued/in flight
//   bus    : alu_cmd_sequencer_if.slave (command, ALU and response buses)
// Build option:
//   ALU_SEQ_CHAIN_EN - when defined, a command with cmd_chain = 1 takes its
//   A operand from the result of the previously issued command.
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_cmd_sequencer_if.slave    bus
);

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

`ifdef ALU_SEQ_CHAIN_EN
    typedef alu_cmd_chain_t cmd_entry_t;
`else
    typedef alu_cmd_t cmd_entry_t;
`endif

    cmd_entry_t     cmd_wdata;
    cmd_entry_t     cmd_head;
    logic [CCW-1:0] cmd_count;
    logic           cmd_ready;
    logic           cmd_push;

    alu_rsp_t       rsp_wdata;
    alu_rsp_t       rsp_head;
    logic [RCW-1:0] rsp_count;
    logic           rsp_valid;
    logic           rsp_pop;

    logic           v1_q, v1_d;
    logic           v2_q;
    alu_data_t      alu_a_q, alu_a_d;
    alu_data_t      alu_b_q, alu_b_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic [RCW:0]   credit_used;
    logic           credit_ok;
    logic           issue;

`ifdef ALU_SEQ_CHAIN_EN
    alu_data_t      last_result_q;
`endif

    // Handshake flags depend only on the registered FIFO counts.
    assign cmd_ready = (cmd_count != CCW'(CMD_DEPTH));
    assign cmd_push  = bus.cmd_valid && cmd_ready;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && bus.rsp_ready;

    // Pack the incoming command; the chain flag is only stored when chaining
    // is built in.
    always_comb begin
        cmd_wdata = '0;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_wdata.chain  = bus.cmd_chain;
        cmd_wdata.cmd.a  = bus.cmd_a;
        cmd_wdata.cmd.b  = bus.cmd_b;
        cmd_wdata.cmd.op = bus.cmd_op;
`else
        cmd_wdata.a  = bus.cmd_a;
        cmd_wdata.b  = bus.cmd_b;
        cmd_wdata.op = bus.cmd_op;
`endif
    end

    alu_sync_fifo #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_push),
        .data_i  (cmd_wdata),
        .pop_i   (issue),
        .data_o  (cmd_head),
        .count_o (cmd_count)
    );

    // Credit check: buffered responses plus results still in the ALU pipe
    // must leave a free slot. A pop on this same edge is deliberately not
    // counted, which keeps the check free of any path from rsp_ready.
    always_comb begin
        credit_used = (RCW+1)'(rsp_count) + (RCW+1)'(v1_q) + (RCW+1)'(v2_q);
        credit_ok   = credit_used < (RCW+1)'(RSP_DEPTH);
    end

    // Issue decision and next values for the ALU operand registers.
    // A chained command waits while its predecessor is still in the operand
    // stage; once it reaches the ALU output it is forwarded directly,
    // otherwise the last captured result is used.
    always_comb begin
        issue    = (cmd_count != '0) && credit_ok;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
`ifdef ALU_SEQ_CHAIN_EN
        if (cmd_head.chain && v1_q) begin
            issue = 1'b0;
        end
        if (issue) begin
            alu_a_d  = cmd_head.chain ? (v2_q ? bus.alu_result : last_result_q)
                                      : cmd_head.cmd.a;
            alu_b_d  = cmd_head.cmd.b;
            alu_op_d = cmd_head.cmd.op;
        end
`else
        if (issue) begin
            alu_a_d  = cmd_head.a;
            alu_b_d  = cmd_head.b;
            alu_op_d = cmd_head.op;
        end
`endif
        v1_d = issue;
    end

    // Operand registers and the two pipeline valid bits tracking the ALU's
    // one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_OP_ADD;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v1_q;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

`ifdef ALU_SEQ_CHAIN_EN
    // Remembers the most recent captured result for chained commands that
    // issue after their predecessor has left the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_result_q <= '0;
        end else if (v2_q) begin
            last_result_q <= bus.alu_result;
        end
    end
`endif

    // Capture the ALU output whenever a valid result is present; the credit
    // check guarantees the response FIFO has room.
    always_comb begin
        rsp_wdata        = '0;
        rsp_wdata.result = bus.alu_result;
        rsp_wdata.carry  = bus.alu_carry;
        rsp_wdata.zero   = bus.alu_zero;
    end

    alu_sync_fifo #(
        .WIDTH ($bits(alu_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (v2_q),
        .data_i  (rsp_wdata),
        .pop_i   (rsp_pop),
        .data_o  (rsp_head),
        .count_o (rsp_count)
    );

    assign bus.cmd_ready  = cmd_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_head.result;
    assign bus.rsp_carry  = rsp_head.carry;
    assign bus.rsp_zero   = rsp_head.zero;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU
// attached to the ALU side of the interface. The final step exercises the
// ALU_SEQ_CHAIN_EN build option when that macro is defined, and checks that
// cmd_chain is ignored when it is not.
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [5:0] exp_q [$];

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: {result, carry/borrow, zero}.
    function automatic logic [5:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        logic [4:0] w;
        case (op)
            ALU_OP_ADD: w = {1'b0, a} + {1'b0, b};
            ALU_OP_SUB: w = {1'b0, a} - {1'b0, b};
            ALU_OP_AND: w = {1'b0, a & b};
            default:    w = {1'b0, a | b};
        endcase
        return {w[3:0], w[4], (w[3:0] == 4'h0)};
    endfunction

    // Registered ALU model driven from the sequencer's operand registers.
    always_ff @(posedge clk) begin
        {bus.alu_result, bus.alu_carry, bus.alu_zero} <= aluRef(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one command and return just after the edge that accepted it.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op, input logic chain);
        int waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_chain = chain;
        while (!bus.cmd_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!bus.cmd_ready) checkOutput("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_chain = 1'b0;
    endtask

    // Wait for a response, compare it, then pop it.
    task automatic popCheck(input string tag, input logic [5:0] expected);
        int waited = 0;
        while (!bus.rsp_valid && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput(tag, 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero}), 32'(expected));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();

        // Reset values
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_data",  32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero}), 32'd0);
        checkOutput("rst_alu_a",     32'(bus.alu_a), 32'd0);
        checkOutput("rst_alu_b",     32'(bus.alu_b), 32'd0);
        checkOutput("rst_alu_op",    32'(bus.alu_op), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single ADD 7+9: 3-cycle latency, result 0 with carry and zero
        $display("[TB] single ADD latency");
        bus.rsp_ready = 1'b1;
        applyStimulus(4'd7, 4'd9, ALU_OP_ADD, 1'b0);
        tick();
        checkOutput("t1_lat_e1", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("t1_lat_e2", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("t1_lat_e3", 32'(bus.rsp_valid), 32'd1);
        checkOutput("t1_add_7_9", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero}), 32'(6'b0000_1_1));
        tick();
        checkOutput("t1_drained", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;

        // Back-to-back SUB / AND / OR, responses in order
        $display("[TB] back-to-back ordering");
        applyStimulus(4'd3, 4'd5, ALU_OP_SUB, 1'b0);
        applyStimulus(4'hC, 4'd3, ALU_OP_AND, 1'b0);
        applyStimulus(4'd0, 4'd0, ALU_OP_OR,  1'b0);
        popCheck("t2_sub_3_5", 6'b1110_1_0);
        popCheck("t2_and_c_3", 6'b0000_0_1);
        popCheck("t2_or_0_0",  6'b0000_0_1);

        // Backpressure: 8 commands with rsp_ready low
        $display("[TB] response backpressure");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'(8 + i), 4'd8, ALU_OP_ADD, 1'b0);
        end
        repeat (6) tick();
        checkOutput("t3_cmd_full",  32'(bus.cmd_ready), 32'd0);
        checkOutput("t3_rsp_held",  32'(bus.rsp_valid), 32'd1);
        repeat (10) tick();
        checkOutput("t3_cmd_stall", 32'(bus.cmd_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            popCheck($sformatf("t3_rsp%0d", i), {4'(i), 1'b1, (i == 0)});
        end
        checkOutput("t3_rsp_empty", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t3_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Random traffic against random response backpressure
        $display("[TB] random traffic");
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    logic [3:0] ra;
                    logic [3:0] rb;
                    logic [1:0] rop;
                    ra  = 4'($urandom_range(15));
                    rb  = 4'($urandom_range(15));
                    rop = 2'($urandom_range(3));
                    exp_q.push_back(aluRef(ra, rb, rop));
                    applyStimulus(ra, rb, rop, 1'b0);
                    if ($urandom_range(3) == 0) tick();
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    bus.rsp_ready = 1'($urandom_range(1));
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("rand_extra_rsp", 32'd1, 32'd0);
                        end else begin
                            checkOutput($sformatf("rand_rsp%0d", got),
                                        32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero}),
                                        32'(exp_q.pop_front()));
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                checkOutput("rand_rsp_count", 32'(got), 32'd200);
                bus.rsp_ready = 1'b0;
            end
        join
        tick();
        checkOutput("rand_rsp_empty", 32'(bus.rsp_valid), 32'd0);

        // Reset with commands in flight
        $display("[TB] reset mid-operation");
        applyStimulus(4'd1, 4'd1, ALU_OP_ADD, 1'b0);
        applyStimulus(4'd2, 4'd2, ALU_OP_ADD, 1'b0);
        applyStimulus(4'd3, 4'd3, ALU_OP_SUB, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_rsp_data",  32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero}), 32'd0);
        checkOutput("mid_rst_alu_a",     32'(bus.alu_a), 32'd0);
        checkOutput("mid_rst_alu_b",     32'(bus.alu_b), 32'd0);
        checkOutput("mid_rst_alu_op",    32'(bus.alu_op), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        begin
            logic seen = 1'b0;
            repeat (8) begin
                tick();
                if (bus.rsp_valid) seen = 1'b1;
            end
            checkOutput("mid_rst_no_rsp", 32'(seen), 32'd0);
        end
        bus.rsp_ready = 1'b0;

`ifdef ALU_SEQ_CHAIN_EN
        // Chained ADD: second command takes A from the first result
        $display("[TB] chained command");
        applyStimulus(4'd2, 4'd3, ALU_OP_ADD, 1'b0);
        applyStimulus(4'd0, 4'd4, ALU_OP_ADD, 1'b1);
        tick();
        checkOutput("chain_bubble_a", 32'(bus.alu_a), 32'd2);
        checkOutput("chain_bubble_b", 32'(bus.alu_b), 32'd3);
        tick();
        checkOutput("chain_issue_a", 32'(bus.alu_a), 32'd5);
        checkOutput("chain_issue_b", 32'(bus.alu_b), 32'd4);
        popCheck("chain_first",  6'b0101_0_0);
        popCheck("chain_second", 6'b1001_0_0);
`else
        // cmd_chain has no effect: cmd_a is always used
        $display("[TB] chain flag ignored");
        applyStimulus(4'd2, 4'd3, ALU_OP_ADD, 1'b0);
        applyStimulus(4'd1, 4'd4, ALU_OP_ADD, 1'b1);
        tick();
        checkOutput("nochain_issue_a", 32'(bus.alu_a), 32'd1);
        checkOutput("nochain_issue_b", 32'(bus.alu_b), 32'd4);
        popCheck("nochain_first",  6'b0101_0_0);
        popCheck("nochain_second", 6'b0101_0_0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream/downstream wrapper for the registered 4-bit ALU. Accepts operand/opcode commands over a valid/ready handshake, buffers them, and issues at most one per cycle to the ALU's A/B/op inputs. It tracks the ALU's one-cycle result latency and captures result, carry and zero flags into a response buffer drained over a second valid/ready handshake. Backpressure from the response side is honoured without ever dropping an ALU result.

## Interface
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2
- RSP_DEPTH, 4: response FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_a, cmd_b  in  4 each  operands
- cmd_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_chain  in  1  use previous result as A (only with ALU_SEQ_CHAIN_EN)
- alu_a, alu_b  out  4 each  registered operands to ALU
- alu_op  out  2  registered opcode to ALU
- alu_result  in  4  ALU registered result
- alu_carry, alu_zero  in  1 each  ALU carry_out / zero_flag
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts
- rsp_result  out  4; rsp_carry, rsp_zero  out  1 each  head of response FIFO

## Operation
- Command push on cmd_valid & cmd_ready; response pop on rsp_valid & rsp_ready. Push and pop on the same edge are both legal on both FIFOs, including push on full when a pop occurs (cmd_ready is !full, so no push on full at command side).
- Pipeline valid bits: v1 (operands held in alu_* this cycle), v2 (ALU output valid this cycle); v2 <= v1 each edge.
- Issue condition: command FIFO non-empty and (rsp_count + v1 + v2) < RSP_DEPTH; a same-cycle pop is not credited. On issue: pop head, load alu_a/alu_b/alu_op, v1 <= 1. Otherwise alu_* hold, v1 <= 0.
- Capture: when v2 = 1, push {alu_result, alu_carry, alu_zero} into response FIFO; credit rule guarantees never full.
- last_result register updated with alu_result on every capture.
- Responses leave in command order; no reordering, no drops.
- Carry for SUB is the ALU's 5th bit (borrow: 1 when A < B); passed through unmodified.
- Reset: alu_a = 0, alu_b = 0, alu_op = 00, v1 = v2 = 0, last_result = 0, both FIFOs empty; therefore cmd_ready = 1, rsp_valid = 0, rsp_* = 0. Reset mid-operation discards all queued and in-flight commands.

## Timing
- Command accepted at edge E0 → issued at E1 → ALU registers at E2 → captured at E3; rsp_valid high after E3 (3-cycle latency with empty pipeline).
- Sustained throughput 1 command/cycle when rsp_ready held high and RSP_DEPTH ≥ 3.
- rsp_ready low: issue stops once rsp_count + in-flight reaches RSP_DEPTH; in-flight results still land.
- cmd_ready and rsp_valid are functions of registered FIFO state only (no combinational path from rsp_ready or cmd_valid).

## Configuration
- ALU_SEQ_CHAIN_EN defined: a command with cmd_chain = 1 replaces A with the result of the immediately preceding issued command. It may issue only when v1 = 0; if v2 = 1, alu_result is forwarded; otherwise last_result is used. Back-to-back dependent commands therefore see one bubble cycle. cmd_chain is stored per FIFO entry.
- Not defined: cmd_chain is ignored (not stored); cmd_a always used; no stall.

## Structure
- Shared package alu_pkg: opcode constants ALU_OP_ADD/SUB/AND/OR, 4-bit data width, response record type {result, carry, zero}.
- One sub-module: alu_sync_fifo (parameterised width/depth, count output), instantiated for commands and responses.

## Test plan
- Single ADD 7+9, rsp_ready = 1 → rsp_valid 3 cycles after acceptance, result 0, carry 1, zero 1.
- SUB 3−5 then AND C&3 then OR 0|0 back-to-back → responses in order: {E,1,0}, {0,0,1}, {0,0,1}.
- rsp_ready = 0, push 8 commands (depths 4) → exactly 4 responses buffered, issue stalls, cmd_ready drops after the 4 unissued entries fill the command FIFO; release rsp_ready → all 8 delivered in order, none lost.
- Random rsp_ready toggling with 200 random commands → scoreboard matches model, rsp never overflows.
- rst_n pulsed low with 3 in flight → outputs return to reset values immediately; no response appears afterwards.
- ALU_SEQ_CHAIN_EN: ADD 2+3, then chained ADD x+4 → second result 9, one bubble cycle between issues.
